// File: rtl/lcd_write_arbiter.sv
// Character-LCD write-path owner: power-up init, then round-robin
// single-character writes (set-DDRAM-address + data) from two requesters.
module lcd_write_arbiter #(
  parameter int unsigned DLY_CYCLES = 262142,
  parameter int unsigned DLY_W      = 18
) (
  input  logic       iCLK,
  input  logic       iRST,
  input  logic       iREQ0,
  input  logic       iROW0,
  input  logic [3:0] iCOL0,
  input  logic [7:0] iCHR0,
  output logic       oACK0,
  input  logic       iREQ1,
  input  logic       iROW1,
  input  logic [3:0] iCOL1,
  input  logic [7:0] iCHR1,
  output logic       oACK1,
  output logic [7:0] oLCD_DATA,
  output logic       oLCD_RS,
  output logic       oLCD_Start,
  input  logic       iLCD_Done,
  output logic       oINIT_DONE,
  output logic       oBUSY
);

  typedef enum logic [3:0] {
    INIT_ISSUE, INIT_WAIT, INIT_DLY, IDLE,
    ADDR_ISSUE, ADDR_WAIT, ADDR_DLY,
    DATA_ISSUE, DATA_WAIT, DATA_DLY, ACK
  } state_t;

  state_t           state, stateN;
  logic [DLY_W-1:0] dlyCnt, dlyCntN;
  logic [1:0]       initIdx, initIdxN;
  logic             curRow, curRowN;
  logic [3:0]       curCol, curColN;
  logic [7:0]       curChr, curChrN;
  logic             curId, curIdN;
  logic             lastId, lastIdN;
  logic [7:0]       dataN;
  logic             rsN, startN, ack0N, ack1N, initDoneN, busyN;
  logic             dlyEnd, anyReq, pick1;

  function automatic logic [7:0] initByte(input logic [1:0] idx);
    case (idx)
      2'd0:    initByte = 8'h38;
      2'd1:    initByte = 8'h0C;
      2'd2:    initByte = 8'h01;
      default: initByte = 8'h06;
    endcase
  endfunction

  assign dlyEnd = (dlyCnt == DLY_W'(DLY_CYCLES - 1));
  assign anyReq = iREQ0 || iREQ1;
  // lastId == 1 means requester 1 was served last, so requester 0 wins a tie
  assign pick1  = iREQ1 && (!iREQ0 || !lastId);

  // state and all registered outputs
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state      <= INIT_ISSUE;
      dlyCnt     <= '0;
      initIdx    <= '0;
      curRow     <= 1'b0;
      curCol     <= '0;
      curChr     <= '0;
      curId      <= 1'b0;
      lastId     <= 1'b1;
      oLCD_DATA  <= '0;
      oLCD_RS    <= 1'b0;
      oLCD_Start <= 1'b0;
      oACK0      <= 1'b0;
      oACK1      <= 1'b0;
      oINIT_DONE <= 1'b0;
      oBUSY      <= 1'b1;
    end else begin
      state      <= stateN;
      dlyCnt     <= dlyCntN;
      initIdx    <= initIdxN;
      curRow     <= curRowN;
      curCol     <= curColN;
      curChr     <= curChrN;
      curId      <= curIdN;
      lastId     <= lastIdN;
      oLCD_DATA  <= dataN;
      oLCD_RS    <= rsN;
      oLCD_Start <= startN;
      oACK0      <= ack0N;
      oACK1      <= ack1N;
      oINIT_DONE <= initDoneN;
      oBUSY      <= busyN;
    end
  end

  // next-state sequencing
  always_comb begin
    stateN = state;
    case (state)
      INIT_ISSUE: stateN = INIT_WAIT;
      INIT_WAIT:  if (iLCD_Done) stateN = INIT_DLY;
      INIT_DLY:   if (dlyEnd) stateN = (initIdx == 2'd3) ? IDLE : INIT_ISSUE;
      IDLE:       if (anyReq && oINIT_DONE) stateN = ADDR_ISSUE;
      ADDR_ISSUE: stateN = ADDR_WAIT;
      ADDR_WAIT:  if (iLCD_Done) stateN = ADDR_DLY;
      ADDR_DLY:   if (dlyEnd) stateN = DATA_ISSUE;
      DATA_ISSUE: stateN = DATA_WAIT;
      DATA_WAIT:  if (iLCD_Done) stateN = DATA_DLY;
      DATA_DLY:   if (dlyEnd) stateN = ACK;
      ACK:        stateN = IDLE;
      default:    stateN = INIT_ISSUE;
    endcase
  end

  // next values for outputs and datapath registers
  // (ack is raised on entry to ACK so the pulse coincides with the ACK state)
  always_comb begin
    dataN     = oLCD_DATA;
    rsN       = oLCD_RS;
    startN    = oLCD_Start;
    ack0N     = 1'b0;
    ack1N     = 1'b0;
    initDoneN = oINIT_DONE;
    dlyCntN   = dlyCnt;
    initIdxN  = initIdx;
    curRowN   = curRow;
    curColN   = curCol;
    curChrN   = curChr;
    curIdN    = curId;
    lastIdN   = lastId;
    busyN     = (stateN != IDLE);
    case (state)
      INIT_ISSUE: begin
        dataN  = initByte(initIdx);
        rsN    = 1'b0;
        startN = 1'b1;
      end
      INIT_WAIT, ADDR_WAIT, DATA_WAIT: begin
        if (iLCD_Done) startN = 1'b0;
      end
      INIT_DLY: begin
        if (dlyEnd) begin
          dlyCntN = '0;
          if (initIdx == 2'd3) initDoneN = 1'b1;
          else                 initIdxN  = initIdx + 2'd1;
        end else begin
          dlyCntN = dlyCnt + 1'b1;
        end
      end
      IDLE: begin
        if (anyReq && oINIT_DONE) begin
          curRowN = pick1 ? iROW1 : iROW0;
          curColN = pick1 ? iCOL1 : iCOL0;
          curChrN = pick1 ? iCHR1 : iCHR0;
          curIdN  = pick1;
          lastIdN = pick1;
        end
      end
      ADDR_ISSUE: begin
        dataN  = {1'b1, curRow, 2'b00, curCol};
        rsN    = 1'b0;
        startN = 1'b1;
      end
      ADDR_DLY: begin
        dlyCntN = dlyEnd ? '0 : dlyCnt + 1'b1;
      end
      DATA_ISSUE: begin
        dataN  = curChr;
        rsN    = 1'b1;
        startN = 1'b1;
      end
      DATA_DLY: begin
        if (dlyEnd) begin
          dlyCntN = '0;
          ack0N   = !curId;
          ack1N   = curId;
        end else begin
          dlyCntN = dlyCnt + 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_lcd_write_arbiter.sv
// Directed bench for lcd_write_arbiter with a 3-cycle Done responder.
module tb_lcd_write_arbiter;

  logic       iCLK = 1'b0;
  logic       iRST;
  logic       iREQ0, iROW0, iREQ1, iROW1;
  logic [3:0] iCOL0, iCOL1;
  logic [7:0] iCHR0, iCHR1;
  logic       oACK0, oACK1;
  logic [7:0] oLCD_DATA;
  logic       oLCD_RS, oLCD_Start;
  logic       iLCD_Done = 1'b0;
  logic       oINIT_DONE, oBUSY;

  int vectors = 0;
  int miscompares = 0;

  logic [8:0] hsQ[$];
  int         ackQ[$];
  int         gapErr = 0, stableErr = 0, fallErr = 0, ackWidthErr = 0;
  int         idleCnt = 0, doneCnt = 0;
  logic       gapArmed = 1'b0, prevStart = 1'b0, prevRst = 1'b1;
  logic       prevAck0 = 1'b0, prevAck1 = 1'b0;
  logic [8:0] prevHs = '0;

  lcd_write_arbiter #(.DLY_CYCLES(4), .DLY_W(3)) dut (
    .iCLK(iCLK), .iRST(iRST),
    .iREQ0(iREQ0), .iROW0(iROW0), .iCOL0(iCOL0), .iCHR0(iCHR0), .oACK0(oACK0),
    .iREQ1(iREQ1), .iROW1(iROW1), .iCOL1(iCOL1), .iCHR1(iCHR1), .oACK1(oACK1),
    .oLCD_DATA(oLCD_DATA), .oLCD_RS(oLCD_RS), .oLCD_Start(oLCD_Start),
    .iLCD_Done(iLCD_Done), .oINIT_DONE(oINIT_DONE), .oBUSY(oBUSY)
  );

  always #5 iCLK = ~iCLK;

  // handshake/ack monitor, then the LCD_Controller Done responder
  always @(negedge iCLK) begin
    if (iLCD_Done && oLCD_Start) fallErr++;
    if (prevStart && !oLCD_Start && !iLCD_Done && !iRST && !prevRst) fallErr++;
    if (oLCD_Start && !prevStart) begin
      hsQ.push_back({oLCD_RS, oLCD_DATA});
      if (gapArmed && idleCnt < 4) gapErr++;
    end
    if (oLCD_Start && prevStart && ({oLCD_RS, oLCD_DATA} != prevHs)) stableErr++;
    if (!oLCD_Start) idleCnt++;
    else             idleCnt = 0;
    if (prevStart && !oLCD_Start) gapArmed = 1'b1;
    if (iRST || prevRst) gapArmed = 1'b0;
    if (oACK0) ackQ.push_back(0);
    if (oACK1) ackQ.push_back(1);
    if ((oACK0 && prevAck0) || (oACK1 && prevAck1) || (oACK0 && oACK1)) ackWidthErr++;

    iLCD_Done = 1'b0;
    if (iRST) begin
      doneCnt = 0;
    end else if (oLCD_Start && !prevStart) begin
      doneCnt = 2;
    end else if (doneCnt == 2) begin
      doneCnt = 1;
    end else if (doneCnt == 1) begin
      iLCD_Done = 1'b1;
      doneCnt = 0;
    end

    prevStart = oLCD_Start;
    prevHs    = {oLCD_RS, oLCD_DATA};
    prevRst   = iRST;
    prevAck0  = oACK0;
    prevAck1  = oACK1;
  end

  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [8:0] hsAt(input int i);
    if (i < hsQ.size()) return hsQ[i];
    return 'x;
  endfunction

  task automatic waitInit(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (oINIT_DONE) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic waitAck(output int who);
    who = -1;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (oACK0) begin who = 0; break; end
      if (oACK1) begin who = 1; break; end
    end
  endtask

  task automatic doReset();
    iRST = 1'b1;
    tick();
    tick();
    hsQ.delete();
    ackQ.delete();
    iRST = 1'b0;
  endtask

  logic ok;
  int   who;
  int   order[4];

  initial begin
    iRST = 1'b1;
    iREQ0 = 1'b0; iROW0 = 1'b0; iCOL0 = '0; iCHR0 = '0;
    iREQ1 = 1'b0; iROW1 = 1'b0; iCOL1 = '0; iCHR1 = '0;
    tick();
    tick();
    // reset state
    chk("rst_start", oLCD_Start, 0);
    chk("rst_data", oLCD_DATA, 0);
    chk("rst_rs", oLCD_RS, 0);
    chk("rst_acks", {oACK1, oACK0}, 0);
    chk("rst_initdone", oINIT_DONE, 0);

    // power-up sequence with no requests
    hsQ.delete();
    ackQ.delete();
    iRST = 1'b0;
    waitInit(ok);
    chk("init_reached", ok, 1);
    tick();
    chk("init_busy", oBUSY, 0);
    chk("init_hs_count", hsQ.size(), 4);
    chk("init_b0", hsAt(0), 9'h038);
    chk("init_b1", hsAt(1), 9'h00C);
    chk("init_b2", hsAt(2), 9'h001);
    chk("init_b3", hsAt(3), 9'h006);
    repeat (5) tick();
    chk("idle_no_hs", hsQ.size(), 4);
    chk("idle_no_ack", ackQ.size(), 0);

    // request held through init
    iREQ0 = 1'b1; iROW0 = 1'b1; iCOL0 = 4'd5; iCHR0 = 8'h41;
    doReset();
    waitInit(ok);
    chk("req_init_reached", ok, 1);
    chk("req_no_early_grant", hsQ.size(), 4);
    chk("req_no_early_ack", ackQ.size(), 0);
    waitAck(who);
    iREQ0 = 1'b0;
    chk("req0_ack_id", who, 0);
    repeat (3) tick();
    chk("req0_addr", hsAt(4), 9'h0C5);
    chk("req0_data", hsAt(5), 9'h141);
    chk("req0_ack_count", ackQ.size(), 1);

    // simultaneous requests after a fresh init
    doReset();
    waitInit(ok);
    chk("tie_init_reached", ok, 1);
    hsQ.delete();
    ackQ.delete();
    iREQ0 = 1'b1; iROW0 = 1'b0; iCOL0 = 4'd0;  iCHR0 = 8'h50;
    iREQ1 = 1'b1; iROW1 = 1'b1; iCOL1 = 4'd15; iCHR1 = 8'h37;
    waitAck(who);
    iREQ0 = 1'b0;
    chk("tie_first_ack", who, 0);
    waitAck(who);
    iREQ1 = 1'b0;
    chk("tie_second_ack", who, 1);
    chk("tie_hs0", hsAt(0), 9'h080);
    chk("tie_hs1", hsAt(1), 9'h150);
    chk("tie_hs2", hsAt(2), 9'h0CF);
    chk("tie_hs3", hsAt(3), 9'h137);

    // both held: strict alternation
    repeat (3) tick();
    iREQ0 = 1'b1;
    iREQ1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      waitAck(who);
      order[i] = who;
    end
    iREQ0 = 1'b0;
    iREQ1 = 1'b0;
    chk("rr_0", order[0], 0);
    chk("rr_1", order[1], 1);
    chk("rr_2", order[2], 0);
    chk("rr_3", order[3], 1);

    // fields change after grant
    repeat (3) tick();
    hsQ.delete();
    ackQ.delete();
    iREQ0 = 1'b1; iROW0 = 1'b0; iCOL0 = 4'd2; iCHR0 = 8'h41;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (oBUSY) begin ok = 1'b1; break; end
    end
    chk("latch_grant_seen", ok, 1);
    iCHR0 = 8'h42;
    iCOL0 = 4'd9;
    waitAck(who);
    iREQ0 = 1'b0;
    chk("latch_ack", who, 0);
    chk("latch_addr", hsAt(0), 9'h082);
    chk("latch_data", hsAt(1), 9'h141);

    // request withdrawn during ADDR_WAIT
    repeat (3) tick();
    hsQ.delete();
    ackQ.delete();
    iREQ1 = 1'b1; iROW1 = 1'b1; iCOL1 = 4'd0; iCHR1 = 8'h5A;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (oLCD_Start) begin ok = 1'b1; break; end
    end
    chk("wd_addr_wait_seen", ok, 1);
    iREQ1 = 1'b0;
    waitAck(who);
    chk("wd_ack", who, 1);
    chk("wd_addr", hsAt(0), 9'h0C0);
    chk("wd_data", hsAt(1), 9'h15A);

    // reset during DATA_WAIT
    repeat (3) tick();
    iREQ0 = 1'b1; iROW0 = 1'b0; iCOL0 = 4'd1; iCHR0 = 8'h55;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (oLCD_Start && oLCD_RS) begin ok = 1'b1; break; end
    end
    chk("mid_data_wait_seen", ok, 1);
    iRST = 1'b1;
    iREQ0 = 1'b0;
    tick();
    chk("mid_rst_start", oLCD_Start, 0);
    chk("mid_rst_initdone", oINIT_DONE, 0);
    chk("mid_rst_acks", {oACK1, oACK0}, 0);
    hsQ.delete();
    ackQ.delete();
    iRST = 1'b0;
    waitInit(ok);
    chk("mid_reinit_reached", ok, 1);
    chk("mid_reinit_first", hsAt(0), 9'h038);
    chk("mid_reinit_count", hsQ.size(), 4);
    chk("mid_no_ack", ackQ.size(), 0);

    // protocol invariants gathered throughout the run
    chk("gap_min_idle", gapErr, 0);
    chk("start_hold_stable", stableErr, 0);
    chk("start_fall_after_done", fallErr, 0);
    chk("ack_one_cycle", ackWidthErr, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
